// File: rtl/tagged_flow_scheduler.sv
// Multi-flow ingress scheduler: per-flow FIFOs drained onto one tagged write
// port in round-robin bursts whose length is programmable per flow.
module tagged_flow_scheduler #(
  parameter int  FLUX    = 4,
  parameter int  DATA_W  = 8,
  parameter int  DEPTH   = 16,
  parameter int  LEN_W   = 7,
  parameter int  DEF_LEN = 71,
  localparam int TAG_W   = $clog2(FLUX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLUX*DATA_W-1:0]  in_din,
  input  logic [FLUX-1:0]         in_write,
  output logic [FLUX-1:0]         in_full,
  input  logic                    cfg_write,
  input  logic [TAG_W-1:0]        cfg_flow,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic [TAG_W+DATA_W-1:0] out_din,
  output logic                    out_write,
  input  logic [FLUX-1:0]         out_full,
  output logic                    busy,
  output logic [FLUX-1:0]         ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {SEL, SEND} state_t;

  logic [DATA_W-1:0] mem    [FLUX][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [FLUX];
  logic [PTR_W-1:0]  rd_ptr [FLUX];
  logic [CNT_W-1:0]  count  [FLUX];
  logic [LEN_W-1:0]  len    [FLUX];
  logic [LEN_W-1:0]  rem    [FLUX];

  logic [FLUX-1:0]   nonempty;
  logic [FLUX-1:0]   push;
  logic [FLUX-1:0]   pop;

  state_t            state, state_next;
  logic [TAG_W-1:0]  cur, cur_next;
  logic [TAG_W-1:0]  last, last_next;
  logic [TAG_W-1:0]  grant;
  logic              grant_valid;
  logic              fire;
  logic              load_rem;
  logic [DATA_W-1:0] head;

  // in_full reflects the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      nonempty[f] = (count[f] != '0);
      in_full[f]  = (count[f] == CNT_W'(DEPTH));
      push[f]     = in_write[f] & ~in_full[f];
    end
  end

  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (push[f]) mem[f][wr_ptr[f]] <= in_din[f*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
        count[f]  <= '0;
      end
      ovf <= '0;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (push[f]) wr_ptr[f] <= wr_ptr[f] + PTR_W'(1);
        if (pop[f])  rd_ptr[f] <= rd_ptr[f] + PTR_W'(1);
        if (push[f] && !pop[f])      count[f] <= count[f] + CNT_W'(1);
        else if (!push[f] && pop[f]) count[f] <= count[f] - CNT_W'(1);
        if (in_write[f] && in_full[f]) ovf[f] <= 1'b1;
      end
    end
  end

  // Round-robin scan starting just after the flow that last held the grant.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = 1; i <= FLUX; i++) begin
      idx = (int'(last) + i) % FLUX;
      if (!grant_valid && nonempty[idx]) begin
        grant_valid = 1'b1;
        grant       = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    cur_next   = cur;
    last_next  = last;
    pop        = '0;
    fire       = 1'b0;
    load_rem   = 1'b0;
    case (state)
      SEL: begin
        if (grant_valid) begin
          state_next = SEND;
          cur_next   = grant;
          load_rem   = (rem[grant] == '0);
        end
      end
      SEND: begin
        // An empty FIFO releases the grant but keeps rem, so the burst resumes later.
        if (!nonempty[cur]) begin
          state_next = SEL;
          last_next  = cur;
        end else if (!out_full[cur]) begin
          fire     = 1'b1;
          pop[cur] = 1'b1;
          if (rem[cur] <= LEN_W'(1)) begin
            state_next = SEL;
            last_next  = cur;
          end
        end
      end
      default: state_next = SEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SEL;
      cur   <= '0;
      last  <= TAG_W'(FLUX - 1);
    end else begin
      state <= state_next;
      cur   <= cur_next;
      last  <= last_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        len[f] <= LEN_W'(DEF_LEN);
        rem[f] <= '0;
      end
    end else begin
      if (cfg_write) len[cfg_flow] <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      if (load_rem)  rem[grant]    <= len[grant];
      if (fire)      rem[cur]      <= rem[cur] - LEN_W'(1);
    end
  end

  assign head = mem[cur][rd_ptr[cur]];
  assign busy = (state == SEND);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_din   <= '0;
      out_write <= 1'b0;
    end else begin
      out_write <= fire;
      if (fire) out_din <= {cur, head};
    end
  end

endmodule

// File: doc/tagged_flow_scheduler.md
# tagged_flow_scheduler

Synthesizable multi-flow ingress scheduler for the multi-dataflow HEVC interpolation accelerators. It buffers FLUX independent pixel streams in per-flow FIFOs. It forwards them onto one shared, flow-tagged write port in round-robin bursts, with a programmable burst length per flow. It sits between the flow sources and the `write_port_in_port` of the shared datapath, in place of software/bench-side block interleaving.

## Interface
Parameters:
- FLUX, 4, number of flows (≥2); TAG_W = $clog2(FLUX), derived.
- DATA_W, 8, pixel width.
- DEPTH, 16, per-flow FIFO depth (power of 2).
- LEN_W, 7, burst-length register width.
- DEF_LEN, 71, reset burst length of every flow (1..2^LEN_W-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_din  in  FLUX*DATA_W  flow f occupies slice [f*DATA_W +: DATA_W].
- in_write  in  FLUX  per-flow write strobe.
- in_full  out  FLUX  per-flow FIFO full (count == DEPTH).
- cfg_write  in  1  load burst length.
- cfg_flow  in  TAG_W  flow selected by cfg_write.
- cfg_len  in  LEN_W  burst length; 0 is stored as 1.
- out_din  out  TAG_W+DATA_W  {tag, pixel}, registered.
- out_write  out  1  out_din valid, registered.
- out_full  in  FLUX  per-flow downstream full.
- busy  out  1  a flow currently holds the grant.
- ovf  out  FLUX  sticky: a write was dropped because in_full was high.

## Operation
- Per-flow FIFO: a write with in_full[f]=1 is dropped and sets ovf[f]. in_full is evaluated before the same-cycle read. ovf clears only on reset.
- Per-flow state:
  - len[f]: burst length, loaded by cfg_write.
  - rem[f]: residual count of the current burst; 0 means no burst is open.
- FSM states:
  - SEL: scan flows starting at (last+1) mod FLUX and grant the first flow whose FIFO is non-empty. When granting flow g, if rem[g]==0 then load rem[g]=len[g]. Set cur=g and go to SEND. If no flow is eligible, stay in SEL.
  - SEND: each cycle, if FIFO[cur] is non-empty and out_full[cur]==0:
    - pop one element;
    - register out_din={cur, data} with out_write=1;
    - decrement rem[cur].
  - SEND exit conditions:
    - rem[cur] reaches 0 → last=cur, go to SEL.
    - FIFO[cur] empty while rem[cur]>0 → release the grant (last=cur, go to SEL); rem[cur] is retained, so the burst resumes at its next grant.
    - out_full[cur]=1 → stall in SEND, grant held, out_write=0.
- cfg_write to a flow with an open burst changes only len; rem is untouched, and the new length applies at the next burst start.
- Tag ordering: within a flow, elements leave in arrival order. Across flows, output is burst-interleaved.
- busy=1 exactly while in SEND.

## Timing
- Reset values:
  - outputs: out_din=0, out_write=0, in_full=0, busy=0, ovf=0;
  - internal: FIFOs empty, len[*]=DEF_LEN, rem[*]=0, state SEL, last=FLUX-1 (flow 0 is scanned first).
- Latency: an element written at edge k into an idle scheduler is granted at edge k+1 and appears with out_write=1 after edge k+2.
- Throughput: 1 element/cycle inside a burst. Every grant change costs one SEL cycle with out_write=0.
- A pop and a write to the same FIFO in the same cycle are both performed; the count is unchanged.
- out_full is sampled in the same cycle as the pop decision. There is no skid: the downstream must assert out_full while it still has at least 1 free slot.
- Reset asserted mid-burst: all state returns to reset values at the next edge, and out_write=0 at the following output.

## Test plan
- Single flow: cfg len[0]=4, write 10 pixels 0x01..0x0A to flow 0 → out: 0x001..0x004, idle SEL cycle, 0x005..0x008, SEL, 0x009..0x00A. Then rem[0]=2 remains open.
- Four flows, len=3 each, all FIFOs pre-filled with 6 elements → tag order 0,0,0,1,1,1,2,2,2,3,3,3,0,…; 24 outputs with a one-cycle gap at each switch; busy drops after the last output.
- Starvation: len[1]=8, only 3 elements available in flow 1 → 3 outputs, grant released, rem[1]=5. After 5 more writes → exactly 5 more outputs before flow 1 moves on.
- Backpressure: out_full[2]=1 for 5 cycles mid-burst → no out_write, grant held on flow 2, no element lost; output resumes the cycle after release.
- Overflow: 17 writes to flow 3 with out_full[3]=1 and DEPTH=16 → in_full[3]=1 after the 16th write; the 17th write is dropped and ovf[3]=1. The output later shows exactly 16 elements.
- Reset (rst=0) asserted mid-burst → next cycle: out_write=0, busy=0, FIFOs empty, len restored to 71. A subsequent write yields its first output at k+2.
